// File: rtl/otter_io_pkg.sv
// otter_io_pkg
// Shared definitions for the OTTER timer / interrupt controller slice.
//   - register word selects (iobus_addr[3:2]) for the 16-byte window
//   - CTRL and STATUS bit positions
//   - button debounce FSM state encoding
package otter_io_pkg;

    // Word selects within the register window; iobus_addr[1:0] is ignored.
    localparam logic [1:0] REG_CTRL   = 2'd0;  // +0x0
    localparam logic [1:0] REG_TERM   = 2'd1;  // +0x4
    localparam logic [1:0] REG_COUNT  = 2'd2;  // +0x8
    localparam logic [1:0] REG_STATUS = 2'd3;  // +0xC

    // CTRL bit indices
    localparam int CTRL_TMR_EN      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_TMR_IE      = 2;
    localparam int CTRL_BTN_IE      = 3;

    // STATUS bit indices
    localparam int STAT_TMR_PEND = 0;
    localparam int STAT_BTN_PEND = 1;

    typedef enum logic [1:0] {
        DB_LOW       = 2'd0,
        DB_WAIT_HIGH = 2'd1,
        DB_HIGH      = 2'd2,
        DB_WAIT_LOW  = 2'd3
    } db_state_e;

endpackage

// File: rtl/otter_timer_intc_if.sv
// otter_timer_intc_if
// MCU IOBUS slice seen by the timer / interrupt controller.
//   iobus_addr : address from the MCU
//   iobus_out  : store data from the MCU
//   iobus_wr   : store strobe
//   iobus_in   : read data back to the MCU (0 when the window is not hit)
//   rd_hit     : address decodes into this block's window
//
// Transfer semantics: there is no valid/ready pair. A store is accepted on
// every rising edge where iobus_wr=1 and the address hits the window; it
// cannot be stalled. Reads are combinational on iobus_addr with no strobe.
interface otter_timer_intc_if;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_in;
    logic        rd_hit;

    modport master (
        output iobus_addr, iobus_out, iobus_wr,
        input  iobus_in, rd_hit
    );

    modport slave (
        input  iobus_addr, iobus_out, iobus_wr,
        output iobus_in, rd_hit
    );
endinterface

// File: rtl/otter_timer_intc_btn_debounce.sv
// btn_debounce
// Two-flop synchronizer followed by a LOW/WAIT_HIGH/HIGH/WAIT_LOW debounce
// FSM. A level change is accepted after DEBOUNCE_CYCLES consecutive synced
// samples of the new level; the sample that leaves the stable state counts
// as the first of them.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_in     : raw asynchronous button, active-high
//   press      : one-cycle pulse, high in the cycle before the edge that
//                moves WAIT_HIGH -> HIGH
//   dbg_state  : current FSM state
module btn_debounce
    import otter_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      btn_in,
    output logic      press,
    output db_state_e dbg_state
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync_q1, sync_q2;
    db_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DB_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds the number of consecutive new-level samples seen so far.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        case (state)
            DB_LOW: begin
                if (sync_q2) begin
                    state_nxt = DB_WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_WAIT_HIGH: begin
                if (!sync_q2) begin
                    state_nxt = DB_LOW;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = DB_HIGH;
                    cnt_nxt   = '0;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DB_HIGH: begin
                if (!sync_q2) begin
                    state_nxt = DB_WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_WAIT_LOW: begin
                if (sync_q2) begin
                    state_nxt = DB_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = DB_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: rtl/otter_timer_intc.sv
// otter_timer_intc
// Memory-mapped timer plus debounced-button interrupt controller on the
// OTTER MCU IOBUS. Registers (word-aligned, 16-byte window at BASE_ADDR):
//   +0x0 CTRL   R/W   [0] tmr_en [1] auto_reload [2] tmr_ie [3] btn_ie
//   +0x4 TERM   R/W   timer period in cycles (0 = timer holds)
//   +0x8 COUNT  RO
//   +0xC STATUS R/W1C [0] tmr_pend [1] btn_pend
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : IOBUS slave (iobus_addr/out/wr in, iobus_in/rd_hit out)
//   btn_in     : raw asynchronous button
//   intr       : registered level interrupt to the MCU
module otter_timer_intc
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1100_0100,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    otter_timer_intc_if.slave bus,
    input  logic              btn_in,
    output logic              intr
);

    logic [3:0]  ctrl, ctrl_nxt;
    logic [31:0] term;
    logic [31:0] count, count_nxt;
    logic [1:0]  status, status_nxt;
    logic [31:0] rd_data;
    logic        hit, wr_hit;
    logic [1:0]  sel;
    logic        expire, en_nxt;
    logic [1:0]  w1c_mask;
    logic        btn_press;
    db_state_e   unused_db_state;
    logic        unused_addr_lsb;

    assign hit             = (bus.iobus_addr[31:4] == BASE_ADDR[31:4]);
    assign sel             = bus.iobus_addr[3:2];
    assign wr_hit          = hit & bus.iobus_wr;
    assign unused_addr_lsb = ^bus.iobus_addr[1:0];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .press    (btn_press),
        .dbg_state(unused_db_state)
    );

    // Timer step. Comparing against TERM-1 only (never >=) means a TERM
    // written below COUNT lets COUNT run through the 32-bit wrap first.
    always_comb begin
        count_nxt = count;
        expire    = 1'b0;
        en_nxt    = ctrl[CTRL_TMR_EN];
        if (ctrl[CTRL_TMR_EN] && (term != 32'd0)) begin
            if (count == (term - 32'd1)) begin
                count_nxt = 32'd0;
                expire    = 1'b1;
                if (!ctrl[CTRL_AUTO_RELOAD]) begin
                    en_nxt = 1'b0;
                end
            end else begin
                count_nxt = count + 32'd1;
            end
        end
    end

    // A CTRL store on the same edge as a one-shot expiry takes priority
    // over the automatic tmr_en clear: software intent wins.
    always_comb begin
        ctrl_nxt = {ctrl[3:1], en_nxt};
        if (wr_hit && (sel == REG_CTRL)) begin
            ctrl_nxt = bus.iobus_out[3:0];
        end
    end

    // Set events are OR-ed in after the W1C mask, so set wins on a tie.
    always_comb begin
        w1c_mask = 2'b00;
        if (wr_hit && (sel == REG_STATUS)) begin
            w1c_mask = bus.iobus_out[1:0];
        end
        status_nxt = (status & ~w1c_mask) | {btn_press, expire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl   <= 4'd0;
            term   <= 32'd0;
            count  <= 32'd0;
            status <= 2'b00;
            intr   <= 1'b0;
        end else begin
            ctrl   <= ctrl_nxt;
            count  <= count_nxt;
            status <= status_nxt;
            if (wr_hit && (sel == REG_TERM)) begin
                term <= bus.iobus_out;
            end
            intr <= (status[STAT_TMR_PEND] & ctrl[CTRL_TMR_IE]) |
                    (status[STAT_BTN_PEND] & ctrl[CTRL_BTN_IE]);
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (hit) begin
            case (sel)
                REG_CTRL:   rd_data = {28'd0, ctrl};
                REG_TERM:   rd_data = term;
                REG_COUNT:  rd_data = count;
                REG_STATUS: rd_data = {30'd0, status};
                default:    rd_data = 32'd0;
            endcase
        end
    end

    assign bus.iobus_in = rd_data;
    assign bus.rd_hit   = hit;

endmodule

// File: doc/otter_timer_intc.md
OTTER_TIMER_INTC -- requirements
Module: otter_timer_intc

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1100_0100: base of the 16-byte register window on the IOBUS.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a button level change.
REQ-003 clk  input  1: single clock, rising-edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 iobus_addr  input  32: MCU IOBUS_ADDR.
REQ-006 iobus_out  input  32: MCU IOBUS_OUT (write data).
REQ-007 iobus_wr  input  1: MCU IOBUS_WR strobe, one cycle per store.
REQ-008 btn_in  input  1: raw asynchronous button, active-high.
REQ-009 iobus_in  output  32: read data to MCU IOBUS_IN; 0 when no register hit.
REQ-010 rd_hit  output  1: iobus_addr decodes into this block's window (for the external IOBUS_IN mux).
REQ-011 intr  output  1: registered, level interrupt request to MCU INTR.

Function
REQ-012 Register map, word-aligned, addr[1:0] ignored: +0x0 CTRL (R/W), +0x4 TERM (R/W), +0x8 COUNT (RO), +0xC STATUS (R/W1C); other bits of iobus_addr must match BASE_ADDR exactly.
REQ-013 CTRL bits: [0] tmr_en, [1] auto_reload, [2] tmr_ie, [3] btn_ie; [31:4] read 0, writes ignored.
REQ-014 Writes occur on the rising edge where iobus_wr=1 and address hits; new value is visible in the next cycle.
REQ-015 Reads are combinational: iobus_in reflects the addressed register in the same cycle as iobus_addr.
REQ-016 Writes to COUNT are ignored; writing CTRL or TERM does not reset COUNT.
REQ-017 Timer: while tmr_en=1 and TERM!=0, COUNT increments by 1 each cycle.
REQ-018 Expiry: on the cycle where COUNT==TERM-1 and it would increment, COUNT becomes 0 and tmr_pend sets; period is exactly TERM cycles.
REQ-019 Expiry with auto_reload=0 clears tmr_en on that same edge (one-shot); with auto_reload=1 the timer keeps running.
REQ-020 TERM=0: no expiry; COUNT holds its value.
REQ-021 Writing TERM below the current COUNT: COUNT wraps through 32'hFFFF_FFFF to 0 with no expiry, then counts normally.
REQ-022 tmr_en=0 freezes COUNT.
REQ-023 Button path: 2-flop synchronizer, then a debounce FSM with states LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-024 LOW->WAIT_HIGH on synced 1; WAIT_HIGH->HIGH after DEBOUNCE_CYCLES consecutive 1s; WAIT_HIGH->LOW on any 0 (counter cleared). WAIT_LOW/HIGH mirror this for 0s.
REQ-025 The WAIT_HIGH->HIGH transition sets btn_pend; the release transition does not.
REQ-026 STATUS: [0] tmr_pend, [1] btn_pend; a write of 1 clears the bit, a write of 0 has no effect.
REQ-027 If a set event and a W1C clear hit the same bit in the same cycle, set wins.
REQ-028 intr is registered: intr <= (tmr_pend & tmr_ie) | (btn_pend & btn_ie); one-cycle latency from the pending or enable change.
REQ-029 Pending bits latch regardless of the ie bits; enabling ie later asserts intr.

Reset
REQ-030 On rst_n=0, asynchronously: CTRL=0, TERM=0, COUNT=0, STATUS=0, intr=0, synchronizer flops=0, FSM=LOW, debounce counter=0.
REQ-031 Reset asserted mid-count or mid-debounce discards all state; after rst_n deasserts, no interrupt fires until reprogrammed.
REQ-032 iobus_in and rd_hit are purely combinational and follow the reset register values.

Structure
REQ-033 Shared package otter_io_pkg holds the register offsets, CTRL/STATUS bit indices, and the debounce state enum.
REQ-034 Sub-module btn_debounce (synchronizer + FSM + counter, parameter DEBOUNCE_CYCLES) outputs a one-cycle press pulse; everything else lives in otter_timer_intc.

Verification (DEBOUNCE_CYCLES=4 on the bench)
REQ-035 Write TERM=5, CTRL=0x5 -> tmr_pend sets 5 cycles after the first count cycle, intr high one cycle later, tmr_en reads 0 afterwards.
REQ-036 CTRL=0x7, TERM=3 -> expiries every 3 cycles; W1C STATUS=1 drops intr; pend set on the same edge as the W1C -> pend stays 1.
REQ-037 btn_in high for 3 cycles, low, then high for 6 cycles -> only the second press sets btn_pend; with btn_ie=0 intr stays 0 until CTRL=0x8 is written.
REQ-038 COUNT=10 running, write TERM=4 -> COUNT wraps through 0xFFFF_FFFF with no expiry (bench forces COUNT near the top); TERM=0 -> COUNT holds.
REQ-039 rst_n pulsed low mid-count with pend=1 -> all registers 0 and intr 0 immediately; reads of BASE_ADDR+0x10 -> rd_hit=0, iobus_in=0.
